// File: rtl/ifu_prefetch_if.sv
// Instruction bus between the prefetch unit (master) and instruction memory (slave).
// Single outstanding request: req/addr held until gnt, one rvalid beat per grant.
interface ifu_prefetch_if;
    logic        ibus_req_o;
    logic [31:0] ibus_addr_o;
    logic        ibus_gnt_i;
    logic        ibus_rvalid_i;
    logic [31:0] ibus_rdata_i;

    modport master (
        output ibus_req_o,
        output ibus_addr_o,
        input  ibus_gnt_i,
        input  ibus_rvalid_i,
        input  ibus_rdata_i
    );

    modport slave (
        input  ibus_req_o,
        input  ibus_addr_o,
        output ibus_gnt_i,
        output ibus_rvalid_i,
        output ibus_rdata_i
    );
endinterface

// File: rtl/ifu_prefetch.sv
// Instruction prefetch: fetches sequential words into a 2-entry {addr, inst} queue
// whose head feeds the IF/ID register; redirects flush the queue and retarget fetch.
module ifu_prefetch #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter logic [31:0] INST_NOP   = 32'h0000_0013
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           jump_flag_i,
    input  logic [31:0]    jump_addr_i,
    input  logic [2:0]     hold_flag_i,
    ifu_prefetch_if.master ibus,
    output logic [31:0]    inst_o,
    output logic [31:0]    inst_addr_o,
    output logic           inst_valid_o
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DROP} state_t;

    state_t      r_state;
    logic        r_req;
    logic [31:0] r_fetch_pc;
    logic [31:0] r_pending_addr;
    logic [1:0]  r_cnt;
    logic        r_rd_ptr;
    logic [31:0] r_fifo_addr [2];
    logic [31:0] r_fifo_inst [2];

    logic        w_pop;
    logic        w_push;
    logic        w_launch;
    logic        w_wr_ptr;
    logic [1:0]  w_cnt_next;
    logic [31:0] w_jump_pc;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & ~32'h3;
    endfunction

    // A request is only launched when the queue will still have a free slot, and
    // nothing else can push while it is in flight, so that slot stays reserved.
    always_comb begin
        w_jump_pc  = word_align(jump_addr_i);
        w_pop      = (r_cnt != 2'd0) && (hold_flag_i < 3'd2) && !jump_flag_i;
        w_push     = (r_state == S_WAIT) && ibus.ibus_rvalid_i && !jump_flag_i;
        w_cnt_next = jump_flag_i ? 2'd0 : (r_cnt - {1'b0, w_pop} + {1'b0, w_push});
        w_launch   = (w_cnt_next < 2'd2) && (hold_flag_i == 3'd0) && !jump_flag_i;
        w_wr_ptr   = r_rd_ptr ^ r_cnt[0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_req      <= 1'b0;
            r_fetch_pc <= RESET_ADDR;
            r_cnt      <= 2'd0;
            r_rd_ptr   <= 1'b0;
        end else begin
            r_cnt <= w_cnt_next;
            if (jump_flag_i) begin
                r_rd_ptr <= 1'b0;
            end else if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            if (jump_flag_i) begin
                r_fetch_pc <= w_jump_pc;
            end
            r_req <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_launch) begin
                        r_state <= S_REQ;
                        r_req   <= 1'b1;
                    end
                end
                S_REQ: begin
                    // A grant coinciding with a redirect still owes one response beat.
                    if (jump_flag_i) begin
                        r_state <= ibus.ibus_gnt_i ? S_DROP : S_IDLE;
                    end else if (ibus.ibus_gnt_i) begin
                        r_fetch_pc <= r_fetch_pc + 32'd4;
                        r_state    <= S_WAIT;
                    end else begin
                        r_req <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (jump_flag_i) begin
                        r_state <= ibus.ibus_rvalid_i ? S_IDLE : S_DROP;
                    end else if (ibus.ibus_rvalid_i) begin
                        if (w_launch) begin
                            r_state <= S_REQ;
                            r_req   <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_DROP: begin
                    if (ibus.ibus_rvalid_i) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if ((r_state == S_REQ) && ibus.ibus_gnt_i) begin
            r_pending_addr <= r_fetch_pc;
        end
        if (w_push) begin
            r_fifo_addr[w_wr_ptr] <= r_pending_addr;
            r_fifo_inst[w_wr_ptr] <= ibus.ibus_rdata_i;
        end
    end

    assign ibus.ibus_req_o  = r_req;
    assign ibus.ibus_addr_o = r_fetch_pc;
    assign inst_valid_o     = (r_cnt != 2'd0);
    assign inst_o           = inst_valid_o ? r_fifo_inst[r_rd_ptr] : INST_NOP;
    assign inst_addr_o      = inst_valid_o ? r_fifo_addr[r_rd_ptr] : 32'd0;

endmodule

// File: tb/tb_ifu_prefetch.sv
// Bench for ifu_prefetch: memory responder plus an instruction-stream reference model
// (sequential addresses from the last redirect/reset, data from a fixed hash).
module tb_ifu_prefetch;
    localparam logic [31:0] RESET_ADDR = 32'h0000_0000;
    localparam logic [31:0] INST_NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        jump_flag_i;
    logic [31:0] jump_addr_i;
    logic [2:0]  hold_flag_i;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        inst_valid_o;

    ifu_prefetch_if bus();

    ifu_prefetch #(.RESET_ADDR(RESET_ADDR), .INST_NOP(INST_NOP)) dut (
        .clk          (clk),
        .rst          (rst),
        .jump_flag_i  (jump_flag_i),
        .jump_addr_i  (jump_addr_i),
        .hold_flag_i  (hold_flag_i),
        .ibus         (bus),
        .inst_o       (inst_o),
        .inst_addr_o  (inst_addr_o),
        .inst_valid_o (inst_valid_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    logic        d_rst = 1'b1, d_jump = 1'b0;
    logic [31:0] d_jaddr = 32'd0;
    logic [2:0]  d_hold = 3'd0;

    bit          gnt_en = 1'b1, rnd_bus = 1'b0, outst = 1'b0;
    int          gnt_dly = 0, lat = 1, wait_cnt = 0, remain = 0, n_pop = 0;
    logic [31:0] out_addr = 32'd0;

    logic        o_req = 1'b0, o_valid = 1'b0;
    logic [31:0] o_addr = 32'd0, o_inst = 32'd0, o_iaddr = 32'd0;
    logic        p_req = 1'b0, p_gnt = 1'b0, p_jump = 1'b0, p_rst = 1'b1, p_valid = 1'b0;
    logic [2:0]  p_hold = 3'd0;
    logic [31:0] p_addr = 32'd0, p_iaddr = 32'd0;
    logic [31:0] exp_addr = RESET_ADDR;
    logic [31:0] hs_q[$];
    logic [31:0] pop_q[$];

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_F00D;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic sample();
        o_req   = bus.ibus_req_o;
        o_addr  = bus.ibus_addr_o;
        o_valid = inst_valid_o;
        o_inst  = inst_o;
        o_iaddr = inst_addr_o;
        if (!p_rst) begin
            if (p_req && !p_gnt && !p_jump) begin
                chk("req_held", 32'(o_req), 32'd1);
                chk("req_addr_stable", o_addr, p_addr);
            end
            if (p_valid && (p_hold >= 3'd2) && !p_jump) begin
                chk("head_held_valid", 32'(o_valid), 32'd1);
                chk("head_held_addr", o_iaddr, p_iaddr);
            end
        end
        if (o_req === 1'b1) begin
            chk("req_aligned", {30'd0, o_addr[1:0]}, 32'd0);
            chk("one_outstanding", 32'(outst), 32'd0);
        end
        if (o_valid !== 1'b1) begin
            chk("empty_inst", o_inst, INST_NOP);
            chk("empty_addr", o_iaddr, 32'd0);
        end
    endtask

    // One clock: memory response, input drive, reference pop check, then sample.
    task automatic tick();
        logic        gnt, rvalid;
        logic [31:0] rdata;
        gnt    = 1'b0;
        rvalid = 1'b0;
        rdata  = $urandom;
        if (outst) begin
            remain--;
            if (remain == 0) begin
                rvalid = 1'b1;
                rdata  = mem(out_addr);
                outst  = 1'b0;
            end
        end
        if (d_rst && outst) remain = 1;
        if (o_req && !outst && !rvalid && gnt_en && !d_rst && (wait_cnt >= gnt_dly)) gnt = 1'b1;
        wait_cnt = (o_req && !gnt) ? wait_cnt + 1 : 0;
        if (gnt) begin
            outst    = 1'b1;
            remain   = lat;
            out_addr = o_addr;
            hs_q.push_back(o_addr);
            if (rnd_bus) begin
                gnt_dly = $urandom_range(0, 3);
                lat     = $urandom_range(1, 4);
            end
        end
        rst                = d_rst;
        jump_flag_i        = d_jump;
        jump_addr_i        = d_jaddr;
        hold_flag_i        = d_hold;
        bus.ibus_gnt_i     = gnt;
        bus.ibus_rvalid_i  = rvalid;
        bus.ibus_rdata_i   = rdata;
        if (d_rst) begin
            exp_addr = RESET_ADDR;
        end else if (d_jump) begin
            exp_addr = d_jaddr & ~32'h3;
        end else if ((o_valid === 1'b1) && (d_hold < 3'd2)) begin
            chk("pop_addr", o_iaddr, exp_addr);
            chk("pop_inst", o_inst, mem(exp_addr));
            pop_q.push_back(o_iaddr);
            exp_addr = exp_addr + 32'd4;
            n_pop++;
        end
        p_req = o_req;  p_addr = o_addr;  p_gnt = gnt;  p_jump = d_jump;
        p_rst = d_rst;  p_hold = d_hold;  p_valid = o_valid;  p_iaddr = o_iaddr;
        @(negedge clk);
        sample();
    endtask

    task automatic do_reset();
        d_rst = 1'b1; d_jump = 1'b0; d_hold = 3'd0; d_jaddr = 32'd0;
        tick();
        tick();
        d_rst = 1'b0;
    endtask

    task automatic wait_hs(input logic [31:0] a, input string tag);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            tick();
            if ((hs_q.size() != 0) && (hs_q[hs_q.size()-1] == a)) found = 1'b1;
        end
        chk(tag, 32'(found), 32'd1);
    endtask

    initial begin
        logic [31:0] head, a0;
        int          nreq, base;

        // Reset state and sequential fetch on a fast bus
        gnt_en = 1'b1; gnt_dly = 0; lat = 1;
        do_reset();
        chk("rst_req", 32'(o_req), 32'd0);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_inst", o_inst, INST_NOP);
        chk("rst_iaddr", o_iaddr, 32'd0);
        hs_q.delete(); pop_q.delete();
        tick();
        chk("first_req", 32'(o_req), 32'd1);
        chk("first_addr", o_addr, RESET_ADDR);
        repeat (12) tick();
        chk("seq_hs_cnt", 32'(hs_q.size() >= 3), 32'd1);
        chk("seq_hs0", hs_q[0], 32'h0);
        chk("seq_hs1", hs_q[1], 32'h4);
        chk("seq_hs2", hs_q[2], 32'h8);
        chk("seq_pop_cnt", 32'(pop_q.size() >= 3), 32'd1);
        chk("seq_pop0", pop_q[0], 32'h0);
        chk("seq_pop1", pop_q[1], 32'h4);
        chk("seq_pop2", pop_q[2], 32'h8);

        // Hold at IF level fills the queue; release drains both entries in order
        for (int i = 0; i < 10 && o_valid !== 1'b1; i++) tick();
        chk("fill_start_valid", 32'(o_valid), 32'd1);
        head = o_iaddr;
        d_hold = 3'd2;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("fill_req_idle", 32'(o_req), 32'd0);
            chk("fill_head", o_iaddr, head);
        end
        gnt_en = 1'b0; d_hold = 3'd0; pop_q.delete();
        repeat (3) tick();
        chk("drain_count", 32'(pop_q.size()), 32'd2);
        chk("drain_0", pop_q[0], head);
        chk("drain_1", pop_q[1], head + 32'd4);
        chk("drain_empty", 32'(o_valid), 32'd0);
        gnt_en = 1'b1;

        // Redirect while waiting on the response for 0x8
        lat = 3;
        do_reset();
        wait_hs(32'h8, "jmp_hs8_seen");
        d_jump = 1'b1; d_jaddr = 32'h1002;
        tick();
        d_jump = 1'b0;
        chk("jmp_flush", 32'(o_valid), 32'd0);
        chk("jmp_no_req", 32'(o_req), 32'd0);
        hs_q.delete(); pop_q.delete();
        repeat (15) tick();
        chk("jmp_hs_cnt", 32'(hs_q.size() >= 1), 32'd1);
        chk("jmp_hs0", hs_q[0], 32'h1000);
        chk("jmp_pop_cnt", 32'(pop_q.size() >= 1), 32'd1);
        chk("jmp_pop0", pop_q[0], 32'h1000);

        // Delayed grant keeps the request address stable
        gnt_dly = 3; lat = 1;
        do_reset();
        hs_q.delete();
        tick();
        a0 = o_addr;
        nreq = 0;
        for (int i = 0; i < 10 && hs_q.size() == 0; i++) begin
            if (o_req) begin
                nreq++;
                chk("gdly_addr", o_addr, a0);
            end
            tick();
        end
        chk("gdly_cycles", 32'(nreq), 32'd4);
        gnt_dly = 0;

        // Reset while waiting; late response must be ignored
        lat = 2;
        do_reset();
        wait_hs(RESET_ADDR, "rstw_hs_seen");
        d_rst = 1'b1;
        tick();
        chk("rstw_req", 32'(o_req), 32'd0);
        chk("rstw_valid", 32'(o_valid), 32'd0);
        d_rst = 1'b0;
        tick();
        chk("rstw_after_valid", 32'(o_valid), 32'd0);
        chk("rstw_after_inst", o_inst, 32'h0000_0013);
        chk("rstw_after_req", 32'(o_req), 32'd1);
        chk("rstw_after_addr", o_addr, RESET_ADDR);
        lat = 1; pop_q.delete();
        repeat (8) tick();
        chk("rstw_pop0", pop_q[0], RESET_ADDR);

        // Fetch PC wraps past the top of the address space
        d_jump = 1'b1; d_jaddr = 32'hFFFF_FFFF;
        tick();
        d_jump = 1'b0;
        hs_q.delete(); pop_q.delete();
        repeat (16) tick();
        chk("wrap_pop_cnt", 32'(pop_q.size() >= 2), 32'd1);
        chk("wrap_pop0", pop_q[0], 32'hFFFF_FFFC);
        chk("wrap_pop1", pop_q[1], 32'h0);
        chk("wrap_hs0", hs_q[0], 32'hFFFF_FFFC);
        chk("wrap_hs1", hs_q[1], 32'h0);

        // Random holds, redirects, resets and bus timing against the stream model
        rnd_bus = 1'b1;
        base = n_pop;
        for (int i = 0; i < 2000; i++) begin
            d_hold  = ($urandom_range(0, 9) < 7) ? 3'd0 : 3'($urandom_range(1, 3));
            d_jump  = ($urandom_range(0, 39) == 0);
            d_jaddr = $urandom;
            d_rst   = ($urandom_range(0, 499) == 0);
            tick();
        end
        d_hold = 3'd0; d_jump = 1'b0; d_rst = 1'b0;
        repeat (4) tick();
        chk("rand_progress", 32'((n_pop - base) > 80), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
